tensor_job_ctrl: RTL and testbench

Job sequencer for the tensor core's AXI data movers. It latches a GEMM job (base addresses of A/B/C/D, tile counts M/N/K) from the configuration CSRs on `cfg_start`. It then walks the output-tile loop: read C, read A/B once per k-step, launch compute, write D. It issues tile-granular commands to the read DMA, the compute array and the write DMA, and it raises `cfg_done` back to the CSR block when the last D tile has been written.

---
 rtl/tensor_job_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_tensor_job_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tensor_job_ctrl.sv
// GEMM job sequencer: latches a tile-level job and walks the C / (A,B)*KT / compute / D
// loop, issuing one tile-granular command at a time to the read DMA, compute array and write DMA.
module tensor_job_ctrl #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 256,
    parameter int TILE_BEATS = 16,
    parameter int DIM_WIDTH  = 16
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_A,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_B,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_C,
    input  logic [ADDR_WIDTH-1:0] cfg_base_addr_D,
    input  logic [DIM_WIDTH-1:0]  cfg_m,
    input  logic [DIM_WIDTH-1:0]  cfg_n,
    input  logic [DIM_WIDTH-1:0]  cfg_k,
    input  logic                  cfg_start,
    output logic                  cfg_done,
    output logic                  busy,
    output logic                  rd_cmd_valid,
    input  logic                  rd_cmd_ready,
    output logic [ADDR_WIDTH-1:0] rd_cmd_addr,
    output logic [7:0]            rd_cmd_len,
    output logic [1:0]            rd_cmd_sel,
    input  logic                  rd_done,
    output logic                  comp_start,
    output logic                  comp_first,
    output logic                  comp_last,
    input  logic                  comp_done,
    output logic                  wr_cmd_valid,
    input  logic                  wr_cmd_ready,
    output logic [ADDR_WIDTH-1:0] wr_cmd_addr,
    output logic [7:0]            wr_cmd_len,
    input  logic                  wr_done
);

    localparam int IW = 2 * DIM_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LP_TILE_BYTES = ADDR_WIDTH'(TILE_BEATS * (DATA_WIDTH / 8));
    localparam logic [7:0] LP_LEN = 8'(TILE_BEATS - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_RD_C, S_W_C, S_RD_A, S_W_A, S_RD_B, S_W_B,
        S_COMP, S_W_COMP, S_WR_D, S_W_WR, S_NEXT
    } state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base_a, r_base_b, r_base_c, r_base_d;
    logic [DIM_WIDTH-1:0]  r_mt, r_nt, r_kt;
    logic [DIM_WIDTH-1:0]  r_mi, r_ni, r_ki;
    logic                  r_busy, r_done;
    logic                  w_zero, w_k_last, w_n_last, w_m_last;
    logic [IW-1:0]         w_idx_a, w_idx_b, w_idx_cd;

    function automatic logic [ADDR_WIDTH-1:0] tile_addr(input logic [ADDR_WIDTH-1:0] base,
                                                        input logic [IW-1:0] idx);
        return base + ADDR_WIDTH'(idx) * LP_TILE_BYTES;
    endfunction

    assign w_zero   = (cfg_m == '0) || (cfg_n == '0) || (cfg_k == '0);
    assign w_k_last = (r_ki == r_kt - DIM_WIDTH'(1));
    assign w_n_last = (r_ni == r_nt - DIM_WIDTH'(1));
    assign w_m_last = (r_mi == r_mt - DIM_WIDTH'(1));

    assign w_idx_a  = IW'(r_mi) * IW'(r_kt) + IW'(r_ki);
    assign w_idx_b  = IW'(r_ki) * IW'(r_nt) + IW'(r_ni);
    assign w_idx_cd = IW'(r_mi) * IW'(r_nt) + IW'(r_ni);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (cfg_start && !w_zero) w_next = S_RD_C;
            S_RD_C:   if (rd_cmd_ready) w_next = S_W_C;
            S_W_C:    if (rd_done) w_next = S_RD_A;
            S_RD_A:   if (rd_cmd_ready) w_next = S_W_A;
            S_W_A:    if (rd_done) w_next = S_RD_B;
            S_RD_B:   if (rd_cmd_ready) w_next = S_W_B;
            S_W_B:    if (rd_done) w_next = S_COMP;
            S_COMP:   w_next = S_W_COMP;
            S_W_COMP: if (comp_done) w_next = w_k_last ? S_WR_D : S_RD_A;
            S_WR_D:   if (wr_cmd_ready) w_next = S_W_WR;
            S_W_WR:   if (wr_done) w_next = S_NEXT;
            S_NEXT:   w_next = (w_n_last && w_m_last) ? S_IDLE : S_RD_C;
            default:  w_next = S_IDLE;
        endcase
    end

    // Job registers, loop counters and status flags
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_base_a <= '0;
            r_base_b <= '0;
            r_base_c <= '0;
            r_base_d <= '0;
            r_mt     <= '0;
            r_nt     <= '0;
            r_kt     <= '0;
            r_mi     <= '0;
            r_ni     <= '0;
            r_ki     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_base_a <= cfg_base_addr_A;
                        r_base_b <= cfg_base_addr_B;
                        r_base_c <= cfg_base_addr_C;
                        r_base_d <= cfg_base_addr_D;
                        r_mt     <= cfg_m;
                        r_nt     <= cfg_n;
                        r_kt     <= cfg_k;
                        r_mi     <= '0;
                        r_ni     <= '0;
                        r_ki     <= '0;
                        r_busy   <= !w_zero;
                        r_done   <= w_zero;
                    end
                end
                S_W_COMP: begin
                    if (comp_done && !w_k_last) r_ki <= r_ki + DIM_WIDTH'(1);
                end
                S_W_WR: begin
                    // Done becomes visible the cycle right after the final write response
                    if (wr_done && w_n_last && w_m_last) begin
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                S_NEXT: begin
                    r_ki <= '0;
                    if (!w_n_last) begin
                        r_ni <= r_ni + DIM_WIDTH'(1);
                    end else if (!w_m_last) begin
                        r_ni <= '0;
                        r_mi <= r_mi + DIM_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_cmd_addr = '0;
        rd_cmd_sel  = 2'd0;
        case (r_state)
            S_RD_C: begin
                rd_cmd_addr = tile_addr(r_base_c, w_idx_cd);
                rd_cmd_sel  = 2'd2;
            end
            S_RD_A: begin
                rd_cmd_addr = tile_addr(r_base_a, w_idx_a);
                rd_cmd_sel  = 2'd0;
            end
            S_RD_B: begin
                rd_cmd_addr = tile_addr(r_base_b, w_idx_b);
                rd_cmd_sel  = 2'd1;
            end
            default: ;
        endcase
    end

    assign rd_cmd_valid = (r_state == S_RD_C) || (r_state == S_RD_A) || (r_state == S_RD_B);
    assign rd_cmd_len   = LP_LEN;
    assign comp_start   = (r_state == S_COMP);
    assign comp_first   = comp_start && (r_ki == '0);
    assign comp_last    = comp_start && w_k_last;
    assign wr_cmd_valid = (r_state == S_WR_D);
    assign wr_cmd_addr  = wr_cmd_valid ? tile_addr(r_base_d, w_idx_cd) : '0;
    assign wr_cmd_len   = LP_LEN;
    assign busy         = r_busy;
    assign cfg_done     = r_done;

endmodule

// File: tb/tb_tensor_job_ctrl.sv
// Bench for tensor_job_ctrl: randomized DMA/compute responder checked against a loop-nest
// model of the expected command stream.
module tb_tensor_job_ctrl;

    logic        aclk;
    logic        aresetn;
    logic [31:0] cfg_base_addr_A, cfg_base_addr_B, cfg_base_addr_C, cfg_base_addr_D;
    logic [15:0] cfg_m, cfg_n, cfg_k;
    logic        cfg_start;
    logic        cfg_done, busy;
    logic        rd_cmd_valid, rd_cmd_ready;
    logic [31:0] rd_cmd_addr;
    logic [7:0]  rd_cmd_len;
    logic [1:0]  rd_cmd_sel;
    logic        rd_done;
    logic        comp_start, comp_first, comp_last, comp_done;
    logic        wr_cmd_valid, wr_cmd_ready;
    logic [31:0] wr_cmd_addr;
    logic [7:0]  wr_cmd_len;
    logic        wr_done;

    tensor_job_ctrl dut (
        .aclk(aclk), .aresetn(aresetn),
        .cfg_base_addr_A(cfg_base_addr_A), .cfg_base_addr_B(cfg_base_addr_B),
        .cfg_base_addr_C(cfg_base_addr_C), .cfg_base_addr_D(cfg_base_addr_D),
        .cfg_m(cfg_m), .cfg_n(cfg_n), .cfg_k(cfg_k), .cfg_start(cfg_start),
        .cfg_done(cfg_done), .busy(busy),
        .rd_cmd_valid(rd_cmd_valid), .rd_cmd_ready(rd_cmd_ready), .rd_cmd_addr(rd_cmd_addr),
        .rd_cmd_len(rd_cmd_len), .rd_cmd_sel(rd_cmd_sel), .rd_done(rd_done),
        .comp_start(comp_start), .comp_first(comp_first), .comp_last(comp_last),
        .comp_done(comp_done),
        .wr_cmd_valid(wr_cmd_valid), .wr_cmd_ready(wr_cmd_ready), .wr_cmd_addr(wr_cmd_addr),
        .wr_cmd_len(wr_cmd_len), .wr_done(wr_done)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int          kind;   // 0 read, 1 compute, 2 write
        logic [31:0] addr;
        int          sel;
        bit          first;
        bit          last;
    } ev_t;

    ev_t exp_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: the loop nest written directly from the job definition
    function automatic void build(input logic [31:0] a, b, c, d, input int m, n, k);
        ev_t e;
        exp_q.delete();
        for (int mi = 0; mi < m; mi++) begin
            for (int ni = 0; ni < n; ni++) begin
                e = '{kind: 0, addr: c + 32'(mi * n + ni) * 32'd512, sel: 2, first: 0, last: 0};
                exp_q.push_back(e);
                for (int ki = 0; ki < k; ki++) begin
                    e = '{kind: 0, addr: a + 32'(mi * k + ki) * 32'd512, sel: 0, first: 0, last: 0};
                    exp_q.push_back(e);
                    e = '{kind: 0, addr: b + 32'(ki * n + ni) * 32'd512, sel: 1, first: 0, last: 0};
                    exp_q.push_back(e);
                    e = '{kind: 1, addr: 0, sel: 0, first: (ki == 0), last: (ki == k - 1)};
                    exp_q.push_back(e);
                end
                e = '{kind: 2, addr: d + 32'(mi * n + ni) * 32'd512, sel: 0, first: 0, last: 0};
                exp_q.push_back(e);
            end
        end
    endfunction

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_rdv"},  32'(rd_cmd_valid), 0);
        chk({tag, "_wrv"},  32'(wr_cmd_valid), 0);
        chk({tag, "_cs"},   32'({comp_start, comp_first, comp_last}), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(cfg_done), 0);
        chk({tag, "_rda"},  rd_cmd_addr, 0);
        chk({tag, "_sel"},  32'(rd_cmd_sel), 0);
        chk({tag, "_wra"},  wr_cmd_addr, 0);
        chk({tag, "_len"},  32'({rd_cmd_len, wr_cmd_len}), 32'h0F0F);
    endtask

    task automatic start_job(input logic [31:0] a, b, c, d, input int m, n, k);
        @(negedge aclk);
        cfg_base_addr_A = a; cfg_base_addr_B = b; cfg_base_addr_C = c; cfg_base_addr_D = d;
        cfg_m = 16'(m); cfg_n = 16'(n); cfg_k = 16'(k);
        cfg_start = 1'b1;
        build(a, b, c, d, m, n, k);
        @(negedge aclk);
        cfg_start = 1'b0;
        cfg_base_addr_A = $urandom; cfg_base_addr_B = $urandom;
        cfg_base_addr_C = $urandom; cfg_base_addr_D = $urandom;
        cfg_m = 16'($urandom_range(1, 5)); cfg_n = 16'($urandom_range(1, 5));
        cfg_k = 16'($urandom_range(1, 5));
        if (m != 0 && n != 0 && k != 0) begin
            chk("start_lat", 32'(rd_cmd_valid), 1);
            chk("start_busy", 32'(busy), 1);
            chk("start_done_clr", 32'(cfg_done), 0);
        end
    endtask

    // mode 0: ready high, 1: random ready, 2: ready held low 5 cycles per command
    task automatic run_job(input int mode, input bit inject, input bit abort);
        int rd_cnt = 0, cp_cnt = 0, wr_cnt = 0;
        bit rd_out = 0, cp_out = 0, wr_out = 0;
        int rd_wait = 0, wr_wait = 0;
        bit prev_rv = 0, prev_wv = 0, fin = 0, expect_done = 0;
        logic [31:0] prev_ra = 0, prev_wa = 0;
        logic [1:0]  prev_sel = 0;
        ev_t e;
        for (int cyc = 0; cyc < 4000 && !fin; cyc++) begin
            if (expect_done) begin
                chk("done_set", 32'(cfg_done), 1);
                chk("done_busy", 32'(busy), 0);
                chk("done_noextra", 32'(exp_q.size()), 0);
                fin = 1;
            end else begin
                chk("busy_mid", 32'(busy), 1);
                chk("done_mid", 32'(cfg_done), 0);
                rd_done = 0; comp_done = 0; wr_done = 0;
                if (rd_cnt > 0) begin rd_cnt--; if (rd_cnt == 0) begin rd_done = 1; rd_out = 0; end end
                if (cp_cnt > 0) begin cp_cnt--; if (cp_cnt == 0) begin comp_done = 1; cp_out = 0; end end
                if (wr_cnt > 0) begin
                    wr_cnt--;
                    if (wr_cnt == 0) begin wr_done = 1; wr_out = 0; expect_done = (exp_q.size() == 0); end
                end
                if (!rd_out && $urandom_range(0, 7) == 0) rd_done = 1;
                if (!cp_out && $urandom_range(0, 7) == 0) comp_done = 1;
                if (!wr_out && !expect_done && $urandom_range(0, 7) == 0) wr_done = 1;
                if (prev_rv) begin
                    chk("rd_hold", 32'(rd_cmd_valid), 1);
                    chk("rd_addr_stable", rd_cmd_addr, prev_ra);
                    chk("rd_sel_stable", 32'(rd_cmd_sel), 32'(prev_sel));
                end
                if (prev_wv) begin
                    chk("wr_hold", 32'(wr_cmd_valid), 1);
                    chk("wr_addr_stable", wr_cmd_addr, prev_wa);
                end
                case (mode)
                    0: begin rd_cmd_ready = 1; wr_cmd_ready = 1; end
                    1: begin
                        rd_cmd_ready = ($urandom_range(0, 2) != 0);
                        wr_cmd_ready = ($urandom_range(0, 2) != 0);
                    end
                    default: begin
                        rd_cmd_ready = rd_cmd_valid && (rd_wait >= 5);
                        wr_cmd_ready = wr_cmd_valid && (wr_wait >= 5);
                    end
                endcase
                rd_wait = rd_cmd_valid ? rd_wait + 1 : 0;
                wr_wait = wr_cmd_valid ? wr_wait + 1 : 0;
                cfg_start = inject && (cyc == 10);
                if (cfg_start) begin
                    cfg_base_addr_A = 32'h0AA0_0000; cfg_base_addr_B = 32'h0BB0_0000;
                    cfg_base_addr_C = 32'h0CC0_0000; cfg_base_addr_D = 32'h0DD0_0000;
                end
                if (rd_cmd_valid && rd_cmd_ready) begin
                    if (exp_q.size() == 0) chk("rd_extra", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("rd_kind", 0, 32'(e.kind));
                        chk("rd_addr", rd_cmd_addr, e.addr);
                        chk("rd_sel", 32'(rd_cmd_sel), 32'(e.sel));
                        chk("rd_len", 32'(rd_cmd_len), 15);
                    end
                    rd_cnt = $urandom_range(1, 4); rd_out = 1; rd_wait = 0;
                end
                prev_rv = rd_cmd_valid && !rd_cmd_ready;
                prev_ra = rd_cmd_addr; prev_sel = rd_cmd_sel;
                if (wr_cmd_valid && wr_cmd_ready) begin
                    if (exp_q.size() == 0) chk("wr_extra", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("wr_kind", 2, 32'(e.kind));
                        chk("wr_addr", wr_cmd_addr, e.addr);
                        chk("wr_len", 32'(wr_cmd_len), 15);
                    end
                    wr_cnt = $urandom_range(1, 4); wr_out = 1; wr_wait = 0;
                end
                prev_wv = wr_cmd_valid && !wr_cmd_ready;
                prev_wa = wr_cmd_addr;
                if (comp_start) begin
                    if (exp_q.size() == 0) chk("comp_extra", 1, 0);
                    else begin
                        e = exp_q.pop_front();
                        chk("comp_kind", 1, 32'(e.kind));
                        chk("comp_first", 32'(comp_first), 32'(e.first));
                        chk("comp_last", 32'(comp_last), 32'(e.last));
                    end
                    cp_cnt = $urandom_range(1, 5); cp_out = 1;
                    if (abort) begin
                        rd_done = 0; comp_done = 0; wr_done = 0;
                        @(negedge aclk);
                        aresetn = 1'b0;
                        #1;
                        chk_reset_vals("abort");
                        @(negedge aclk);
                        aresetn = 1'b1;
                        @(negedge aclk);
                        rd_done = 1; comp_done = 1; wr_done = 1;
                        @(negedge aclk);
                        rd_done = 0; comp_done = 0; wr_done = 0;
                        chk_reset_vals("post_abort");
                        fin = 1;
                    end
                end
            end
            if (!fin) @(negedge aclk);
        end
        rd_done = 0; comp_done = 0; wr_done = 0; cfg_start = 0;
        rd_cmd_ready = 0; wr_cmd_ready = 0;
        if (!fin) chk("job_timeout", 0, 1);
    endtask

    initial begin
        aresetn = 1'b0; cfg_start = 0;
        cfg_base_addr_A = 0; cfg_base_addr_B = 0; cfg_base_addr_C = 0; cfg_base_addr_D = 0;
        cfg_m = 0; cfg_n = 0; cfg_k = 0;
        rd_cmd_ready = 0; wr_cmd_ready = 0; rd_done = 0; comp_done = 0; wr_done = 0;
        repeat (3) @(negedge aclk);
        chk_reset_vals("reset");
        aresetn = 1'b1;
        @(negedge aclk);

        start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 1, 1, 1);
        run_job(0, 0, 0);
        repeat (3) @(negedge aclk);
        chk("done_sticky", 32'(cfg_done), 1);

        start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 2, 1, 2);
        run_job(0, 0, 0);

        start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 1, 1, 0);
        chk("zero_done", 32'(cfg_done), 1);
        chk("zero_busy", 32'(busy), 0);
        for (int i = 0; i < 6; i++) begin
            chk("zero_noval", 32'({rd_cmd_valid, wr_cmd_valid, comp_start, busy}), 0);
            @(negedge aclk);
        end

        start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 1, 2, 1);
        run_job(2, 0, 0);

        start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 2, 2, 2);
        run_job(1, 1, 0);

        start_job(32'h1000, 32'h2000, 32'h3000, 32'hFFFF_FE00, 1, 2, 1);
        run_job(1, 0, 0);

        start_job(32'h1000, 32'h2000, 32'h3000, 32'h4000, 2, 1, 2);
        run_job(0, 0, 1);
        start_job(32'h5000, 32'h6000, 32'h7000, 32'h8000, 1, 1, 3);
        run_job(1, 0, 0);

        for (int j = 0; j < 4; j++) begin
            start_job($urandom, $urandom, $urandom, $urandom,
                      $urandom_range(1, 3), $urandom_range(1, 3), $urandom_range(1, 3));
            run_job(1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
